// File: rtl/banked_data_memory.sv
// ----------------------------------------------------------------------------
// banked_data_memory
//   Two-bank data memory for the multicycle datapath. The even bank holds the
//   low lane of every word and the odd bank holds the high lane, so a word
//   access touches both banks and a byte (lane) access touches one. All state
//   changes on the falling clock edge. After reset an optional sequencer
//   zeroes every word. Accesses use a req/ack handshake.
//
// Ports
//   clk        in   system clock (falling-edge active)
//   proc_rst   in   asynchronous active-low reset
//   req        in   access request
//   we         in   1 = write, 0 = read
//   byte_mode  in   1 = single-lane access, 0 = full word
//   addr       in   byte address; [ADDR_W-1:1] = word index, [0] = lane
//   wdata      in   write data (byte mode uses the low lane only)
//   rdata      out  registered read data
//   ack        out  one-cycle completion pulse
//   err        out  one-cycle misaligned word-access pulse
//   busy       out  high while the clear sequence runs
// ----------------------------------------------------------------------------
module banked_data_memory #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 16,
    parameter int SIGN_EXT     = 1,
    parameter int CLR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              req,
    input  logic              we,
    input  logic              byte_mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = ADDR_W - 1;
    localparam int DEPTH = 2 ** IDX_W;
    localparam int L     = DATA_W / 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t           RST_STATE = (CLR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic             RST_BUSY  = (CLR_ON_RESET != 0) ? 1'b1 : 1'b0;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

    // Storage banks: not reset, so contents survive a reset unless cleared.
    logic [L-1:0] even_q [DEPTH];
    logic [L-1:0] odd_q  [DEPTH];

    state_t              state_q,   state_d;
    logic [IDX_W-1:0]    clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    logic                ack_q,     ack_d;
    logic                err_q,     err_d;
    logic                busy_q,    busy_d;

    logic [IDX_W-1:0]    idx_s;
    logic                lane_s;
    logic                misaligned_s;
    logic [L-1:0]        lane_data_s;
    logic                sign_s;
    logic                wr_even_s;
    logic                wr_odd_s;
    logic [IDX_W-1:0]    wr_idx_s;
    logic [L-1:0]        wr_even_data_s;
    logic [L-1:0]        wr_odd_data_s;

    // Address decode and lane selection for byte reads.
    always_comb begin
        idx_s        = addr[ADDR_W-1:1];
        lane_s       = addr[0];
        misaligned_s = ~byte_mode & lane_s;
        if (lane_s) begin
            lane_data_s = odd_q[idx_s];
        end else begin
            lane_data_s = even_q[idx_s];
        end
        sign_s = (SIGN_EXT != 0) ? lane_data_s[L-1] : 1'b0;
    end

    // Next-state, output and bank write-enable logic.
    always_comb begin
        state_d        = state_q;
        clr_ptr_d      = clr_ptr_q;
        rdata_d        = rdata_q;
        ack_d          = 1'b0;
        err_d          = 1'b0;
        busy_d         = busy_q;
        wr_even_s      = 1'b0;
        wr_odd_s       = 1'b0;
        wr_idx_s       = idx_s;
        wr_even_data_s = wdata[L-1:0];
        // A byte write always carries its data in the low lane of wdata.
        wr_odd_data_s  = byte_mode ? wdata[L-1:0] : wdata[DATA_W-1:L];

        case (state_q)
            ST_CLEAR: begin
                // req is ignored entirely while clearing.
                wr_idx_s       = clr_ptr_q;
                wr_even_s      = 1'b1;
                wr_odd_s       = 1'b1;
                wr_even_data_s = {L{1'b0}};
                wr_odd_data_s  = {L{1'b0}};
                clr_ptr_d      = clr_ptr_q + IDX_W'(1);
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            ST_IDLE: begin
                busy_d = 1'b0;
                if (req) begin
                    ack_d = 1'b1;
                    if (misaligned_s) begin
                        err_d = 1'b1;
                    end else if (we) begin
                        if (byte_mode) begin
                            wr_even_s = ~lane_s;
                            wr_odd_s  = lane_s;
                        end else begin
                            wr_even_s = 1'b1;
                            wr_odd_s  = 1'b1;
                        end
                    end else if (byte_mode) begin
                        rdata_d = {{L{sign_s}}, lane_data_s};
                    end else begin
                        rdata_d = {odd_q[idx_s], even_q[idx_s]};
                    end
                end else begin
                    ack_d = 1'b0;
                end
            end
            default: begin
                state_d   = RST_STATE;
                busy_d    = RST_BUSY;
                clr_ptr_d = {IDX_W{1'b0}};
            end
        endcase

        // Reset must never disturb stored contents.
        if (!proc_rst) begin
            wr_even_s = 1'b0;
            wr_odd_s  = 1'b0;
        end else begin
            wr_even_s = wr_even_s;
            wr_odd_s  = wr_odd_s;
        end
    end

    // Control and output registers.
    always_ff @(negedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            state_q   <= RST_STATE;
            clr_ptr_q <= {IDX_W{1'b0}};
            rdata_q   <= {DATA_W{1'b0}};
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= RST_BUSY;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    // Bank writes.
    always_ff @(negedge clk) begin
        if (wr_even_s) begin
            even_q[wr_idx_s] <= wr_even_data_s;
        end
        if (wr_odd_s) begin
            odd_q[wr_idx_s] <= wr_odd_data_s;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_banked_data_memory.sv
// ----------------------------------------------------------------------------
// tb_banked_data_memory
//   Directed bench for banked_data_memory. dut0 uses the default parameters;
//   dut1 uses SIGN_EXT=0 and CLR_ON_RESET=0. Both share the access inputs but
//   have separate resets. Inputs change just after the rising edge, the DUT
//   acts on the falling edge, and outputs are sampled on the next rising edge.
// ----------------------------------------------------------------------------
module tb_banked_data_memory;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic        req, we, byte_mode;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata0, rdata1;
    logic        ack0, ack1, err0, err1, busy0, busy1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    banked_data_memory #(.ADDR_W(6), .DATA_W(16), .SIGN_EXT(1), .CLR_ON_RESET(1)) dut0 (
        .clk(clk), .proc_rst(rst0), .req(req), .we(we), .byte_mode(byte_mode),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
    );

    banked_data_memory #(.ADDR_W(6), .DATA_W(16), .SIGN_EXT(0), .CLR_ON_RESET(0)) dut1 (
        .clk(clk), .proc_rst(rst1), .req(req), .we(we), .byte_mode(byte_mode),
        .addr(addr), .wdata(wdata), .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1)
    );

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs; returns after the falling edge has acted on them.
    task automatic step(input logic r, input logic w, input logic b,
                        input logic [5:0] a, input logic [15:0] d);
        req       = r;
        we        = w;
        byte_mode = b;
        addr      = a;
        wdata     = d;
        @(posedge clk);
    endtask

    // Hold a read request on dut0 while it clears; returns edges until busy fell.
    task automatic run_clear(output int edges, output int bad_pulses);
        edges      = 0;
        bad_pulses = 0;
        for (int i = 1; i <= 100; i++) begin
            step(1'b1, 1'b0, 1'b0, 6'h00, 16'h0000);
            if (ack0 || err0) bad_pulses++;
            if (!busy0) begin
                edges = i;
                break;
            end
        end
    endtask

    initial begin
        int edges, bad;
        rst0 = 1'b0;
        rst1 = 1'b0;
        step(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);

        // Reset state.
        check_eq("rst_rdata0", rdata0, 16'h0000);
        check_eq("rst_ack0",   ack0,   1'b0);
        check_eq("rst_err0",   err0,   1'b0);
        check_eq("rst_busy0",  busy0,  1'b1);
        check_eq("rst_busy1",  busy1,  1'b0);
        check_eq("rst_rdata1", rdata1, 16'h0000);

        // Clear sequence with req held high: 32 edges, no ack/err while busy.
        rst0 = 1'b1;
        rst1 = 1'b1;
        run_clear(edges, bad);
        check_eq("clr_edges", edges, 32);
        check_eq("clr_no_ack_err", bad, 0);

        // First request after clear is acknowledged on the next edge.
        step(1'b1, 1'b0, 1'b0, 6'h3E, 16'h0000);
        check_eq("rd3e_ack",   ack0,   1'b1);
        check_eq("rd3e_err",   err0,   1'b0);
        check_eq("rd3e_rdata", rdata0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        check_eq("idle_ack",   ack0,   1'b0);

        // Word write / word read.
        step(1'b1, 1'b1, 1'b0, 6'h04, 16'h8A3C);
        check_eq("ww04_ack", ack0, 1'b1);
        check_eq("ww04_err", err0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 6'h04, 16'h0000);
        check_eq("wr04_ack",    ack0,   1'b1);
        check_eq("wr04_rdata0", rdata0, 16'h8A3C);
        check_eq("wr04_rdata1", rdata1, 16'h8A3C);

        // Byte writes into each lane (upper wdata bits must be ignored).
        step(1'b1, 1'b1, 1'b1, 6'h06, 16'hABF1);
        step(1'b1, 1'b1, 1'b1, 6'h07, 16'hCD22);
        step(1'b1, 1'b0, 1'b0, 6'h06, 16'h0000);
        check_eq("bw06_word0", rdata0, 16'h22F1);
        check_eq("bw06_word1", rdata1, 16'h22F1);
        step(1'b1, 1'b0, 1'b1, 6'h06, 16'h0000);
        check_eq("br06_sext",  rdata0, 16'hFFF1);
        check_eq("br06_zext",  rdata1, 16'h00F1);
        step(1'b1, 1'b0, 1'b1, 6'h07, 16'h0000);
        check_eq("br07_hi0",   rdata0, 16'h0022);
        check_eq("br07_hi1",   rdata1, 16'h0022);

        // Misaligned word write: err+ack, no write, rdata holds.
        step(1'b1, 1'b1, 1'b0, 6'h09, 16'h1234);
        check_eq("mis_err",   err0,   1'b1);
        check_eq("mis_ack",   ack0,   1'b1);
        check_eq("mis_rdata", rdata0, 16'h0022);
        step(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        check_eq("mis_err_drop", err0,   1'b0);
        check_eq("mis_ack_drop", ack0,   1'b0);
        check_eq("mis_rdata2",   rdata0, 16'h0022);
        step(1'b1, 1'b0, 1'b0, 6'h08, 16'h0000);
        check_eq("rd08", rdata0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 6'h0A, 16'h0000);
        check_eq("rd0a", rdata0, 16'h0000);
        check_eq("rd0a_ack_held", ack0, 1'b1);

        // dut1 (no clear): contents survive reset.
        step(1'b1, 1'b1, 1'b0, 6'h10, 16'h5555);
        rst1 = 1'b0;
        step(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        check_eq("d1_rst_busy",  busy1,  1'b0);
        check_eq("d1_rst_rdata", rdata1, 16'h0000);
        rst1 = 1'b1;
        step(1'b1, 1'b0, 1'b0, 6'h10, 16'h0000);
        check_eq("d1_keep_ack",   ack1,   1'b1);
        check_eq("d1_keep_rdata", rdata1, 16'h5555);
        step(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);

        // dut0: reset pulsed 10 edges into a clear restarts the full sequence.
        rst0 = 1'b0;
        step(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        rst0 = 1'b1;
        repeat (10) step(1'b1, 1'b0, 1'b0, 6'h00, 16'h0000);
        check_eq("mid_busy", busy0, 1'b1);
        rst0 = 1'b0;
        step(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);
        check_eq("mid_rst_busy", busy0, 1'b1);
        rst0 = 1'b1;
        run_clear(edges, bad);
        check_eq("reclr_edges", edges, 32);
        check_eq("reclr_no_ack_err", bad, 0);
        step(1'b1, 1'b0, 1'b0, 6'h04, 16'h0000);
        check_eq("reclr_rd04_0", rdata0, 16'h0000);
        check_eq("reclr_rd04_1", rdata1, 16'h8A3C);
        step(1'b0, 1'b0, 1'b0, 6'h00, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
